// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a 2**ADDR_W byte FIFO feeding an LSB-first shifter.
// Frames run back-to-back while bytes are queued; occupancy and a sticky overflow are reported.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [7:0]        i_wr_data,
  input  logic              i_flush,
  input  logic              i_clr_ovf,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_busy,
  output logic              o_overflow,
  output logic              o_tx
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam int unsigned CNT_W    = $clog2(BAUD_DIV);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;

  state_t            r_state, w_state_d;
  logic [CNT_W-1:0]  r_baud_cnt, w_baud_cnt_d;
  logic [2:0]        r_bit_cnt, w_bit_cnt_d;
  logic [7:0]        r_shift, w_shift_d;
  logic              r_tx, w_tx_d;

  logic              w_full;
  logic              w_empty;
  logic              w_wr;
  logic              w_pop;
  logic              w_ovf_set;
  logic              w_baud_tc;
  logic [7:0]        w_rd_data;

  assign w_full    = (r_count == (ADDR_W+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  // A flush swallows any write on the same edge without counting it as an overflow.
  assign w_wr      = i_wr_en && !w_full && !i_flush;
  assign w_ovf_set = i_wr_en && w_full && !i_flush;
  assign w_baud_tc = (r_baud_cnt == CNT_W'(BAUD_DIV - 1));
  assign w_rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_flush) begin
        r_rd_ptr <= r_wr_ptr;
        r_count  <= '0;
      end else begin
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        unique case ({w_wr, w_pop})
          2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
          2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
          default: r_count <= r_count;
        endcase
      end
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (i_clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_d;
      r_baud_cnt <= w_baud_cnt_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_shift    <= w_shift_d;
      r_tx       <= w_tx_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_baud_cnt_d = r_baud_cnt;
    w_bit_cnt_d  = r_bit_cnt;
    w_shift_d    = r_shift;
    w_tx_d       = r_tx;
    w_pop        = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_tx_d = 1'b1;
        if (!w_empty && !i_flush) begin
          w_pop        = 1'b1;
          w_shift_d    = w_rd_data;
          w_tx_d       = 1'b0;
          w_baud_cnt_d = '0;
          w_state_d    = StStart;
        end
      end
      StStart: begin
        if (w_baud_tc) begin
          w_baud_cnt_d = '0;
          w_bit_cnt_d  = '0;
          w_tx_d       = r_shift[0];
          w_state_d    = StData;
        end else begin
          w_baud_cnt_d = r_baud_cnt + 1'b1;
        end
      end
      StData: begin
        if (w_baud_tc) begin
          w_baud_cnt_d = '0;
          if (r_bit_cnt == 3'd7) begin
            w_tx_d    = 1'b1;
            w_state_d = StStop;
          end else begin
            w_shift_d   = {1'b0, r_shift[7:1]};
            w_tx_d      = r_shift[1];
            w_bit_cnt_d = r_bit_cnt + 1'b1;
          end
        end else begin
          w_baud_cnt_d = r_baud_cnt + 1'b1;
        end
      end
      StStop: begin
        if (w_baud_tc) begin
          w_baud_cnt_d = '0;
          // Chain straight into the next start bit so queued frames have no idle gap.
          if (!w_empty && !i_flush) begin
            w_pop     = 1'b1;
            w_shift_d = w_rd_data;
            w_tx_d    = 1'b0;
            w_state_d = StStart;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_baud_cnt_d = r_baud_cnt + 1'b1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_tx_d    = 1'b1;
      end
    endcase
  end

  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_count    = r_count;
  assign o_busy     = !w_empty || (r_state != StIdle);
  assign o_overflow = r_overflow;
  assign o_tx       = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic, every edge checked against
// a frame-timing model (queue of bytes, frame start cycle, 10 bit-slots of BAUD_DIV cycles).
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int AW       = 4;
  localparam int DEPTH    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          flush = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          full, empty, busy, overflow, tx;
  logic [AW:0]   count;

  uart_tx_fifo #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .ADDR_W  (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (wr_en),
    .i_wr_data (wr_data),
    .i_flush   (flush),
    .i_clr_ovf (clr_ovf),
    .o_full    (full),
    .o_empty   (empty),
    .o_count   (count),
    .o_busy    (busy),
    .o_overflow(overflow),
    .o_tx      (tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes waiting, the byte on the line and the edge its frame began.
  byte unsigned m_q[$];
  bit           m_active = 1'b0;
  int           m_start = 0;
  byte unsigned m_cur = 8'h00;
  bit           m_ovf = 1'b0;
  int           n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_tx(input int e);
    int k;
    if (!m_active) return 1'b1;
    k = (e - m_start) / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  task automatic check_all();
    chk("count", 32'(count), 32'(m_q.size()));
    chk("full", 32'(full), 32'(m_q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(m_q.size() == 0));
    chk("busy", 32'(busy), 32'(m_q.size() > 0 || m_active));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic tick(input logic wr, input logic [7:0] d, input logic fl, input logic clr);
    bit ended, do_pop, wr_ok, ovf_set;
    int sz;
    wr_en   = wr;
    wr_data = d;
    flush   = fl;
    clr_ovf = clr;
    sz      = m_q.size();
    ended   = m_active && (n == m_start + 10 * DIV);
    do_pop  = !fl && sz > 0 && (!m_active || ended);
    wr_ok   = wr && !fl && sz < DEPTH;
    ovf_set = wr && !fl && sz == DEPTH;
    @(posedge clk);
    #1;
    if (fl) m_q.delete();
    if (do_pop) begin
      m_cur    = m_q.pop_front();
      m_start  = n;
      m_active = 1'b1;
    end else if (ended) begin
      m_active = 1'b0;
    end
    if (wr_ok) m_q.push_back(d);
    if (ovf_set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    check_all();
    chk("tx", 32'(tx), 32'(exp_tx(n)));
    n++;
    wr_en   = 1'b0;
    flush   = 1'b0;
    clr_ovf = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_active = 1'b0;
    m_ovf    = 1'b0;
  endtask

  initial begin
    logic [AW:0] peak;
    bit          saw_full;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_all();
    chk("rst_tx", 32'(tx), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single byte 0xA5.
    tick(1'b1, 8'hA5, 1'b0, 1'b0);
    idle(110);
    chk("single_idle_busy", 32'(busy), 32'd0);

    // Burst of 16 bytes while idle.
    peak     = '0;
    saw_full = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick(1'b1, 8'(i), 1'b0, 1'b0);
      if (count > peak) peak = count;
      if (full) saw_full = 1'b1;
    end
    chk("burst_peak", 32'(peak), 32'd15);
    chk("burst_full", 32'(saw_full), 32'd0);
    idle(1620);

    // Overflow: 0x55 on the line, then 17 writes with no pop window.
    tick(1'b1, 8'h55, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clear", 32'(overflow), 32'd0);
    idle(1800);

    // Flush while 0x11 is in its data bits.
    tick(1'b1, 8'h11, 1'b0, 1'b0);
    tick(1'b1, 8'h22, 1'b0, 1'b0);
    tick(1'b1, 8'h33, 1'b0, 1'b0);
    idle(30);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_count", 32'(count), 32'd0);
    idle(120);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_tx", 32'(tx), 32'd1);

    // Write on the stop-bit terminal edge with three bytes queued.
    tick(1'b1, 8'hA1, 1'b0, 1'b0);
    tick(1'b1, 8'hA2, 1'b0, 1'b0);
    tick(1'b1, 8'hA3, 1'b0, 1'b0);
    tick(1'b1, 8'hA4, 1'b0, 1'b0);
    chk("simul_pre", 32'(count), 32'd3);
    for (int i = 0; i < 200 && n != m_start + 10 * DIV; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("simul_cnt", 32'(count), 32'd3);
    idle(450);

    // Random traffic, fast enough to overflow, with occasional clears and flushes.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 19) == 0), 8'($urandom), ($urandom_range(0, 599) == 0),
           ($urandom_range(0, 149) == 0));
    end
    idle(1800);

    // Asynchronous reset while a zero data bit is on the line.
    tick(1'b1, 8'h00, 1'b0, 1'b0);
    idle(25);
    chk("pre_rst_tx", 32'(tx), 32'd0);
    tick(1'b1, 8'h77, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    chk("rst_mid_tx", 32'(tx), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1'b1, 8'hC3, 1'b0, 1'b0);
    idle(110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
